// File: rtl/game_pkg.sv
// Shared definitions for the memory-game controller: default parameter
// values, the controller state set and the Moore output bundle per state.
package game_pkg;

  localparam int DEF_MAX_ROUNDS     = 8;
  localparam int DEF_SHOW_CYCLES    = 50;
  localparam int DEF_TIMEOUT_CYCLES = 1000;
  localparam int DEF_SYM_W          = 2;

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    SHOW,
    INPUT,
    WIN,
    LOSE
  } state_t;

  typedef struct packed {
    logic lfsr_reset;
    logic en;
    logic show_valid;
    logic win;
    logic lose;
  } moore_outs_t;

  // Output flags that hold while the controller sits in a given state.
  function automatic moore_outs_t outs_for(state_t st);
    moore_outs_t o;
    o = '0;
    case (st)
      IDLE: begin
        o.lfsr_reset = 1'b1;
        o.en         = 1'b1;
      end
      SEED:    o.en         = 1'b1;
      SHOW:    o.show_valid = 1'b1;
      WIN:     o.win        = 1'b1;
      LOSE:    o.lose       = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

  function automatic int max_int(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Bundle of game controller signals: pattern source, player buttons and
// the controller status outputs. The controller takes the slave side.
interface game_ctrl_if import game_pkg::*; #(
  parameter int MAX_ROUNDS = DEF_MAX_ROUNDS,
  parameter int SYM_W      = DEF_SYM_W
);
  localparam int IDX_W = max_int(1, $clog2(MAX_ROUNDS));
  localparam int RND_W = $clog2(MAX_ROUNDS + 1);

  logic             start;
  logic             lfsr_begin;
  logic [SYM_W-1:0] seq_sym;
  logic             btn_valid;
  logic [SYM_W-1:0] btn_sym;
  logic             lfsr_reset;
  logic             en;
  logic [IDX_W-1:0] seq_idx;
  logic             show_valid;
  logic [RND_W-1:0] round;
  logic             win;
  logic             lose;

  modport master (
    output start, lfsr_begin, seq_sym, btn_valid, btn_sym,
    input  lfsr_reset, en, seq_idx, show_valid, round, win, lose
  );

  modport slave (
    input  start, lfsr_begin, seq_sym, btn_valid, btn_sym,
    output lfsr_reset, en, seq_idx, show_valid, round, win, lose
  );
endinterface

// File: rtl/game_ctrl_timer.sv
// Saturating cycle timer: synchronous clear, count enable and a
// terminal-count compare against a caller-selected limit.
module cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         done
);
  logic [W-1:0] count;

  // Count up while enabled, holding at the terminal value instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != term)) begin
      count <= count + W'(1);
    end
  end

  assign done = (count == term);
endmodule

// File: rtl/game_ctrl.sv
// Memory-game controller: seeds the pattern LFSR, shows a growing
// symbol sequence, checks the player's replay and reports win/lose.
module game_ctrl import game_pkg::*; #(
  parameter int MAX_ROUNDS     = DEF_MAX_ROUNDS,
  parameter int SHOW_CYCLES    = DEF_SHOW_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int SYM_W          = DEF_SYM_W
) (
  input logic        clk,
  input logic        reset,
  game_ctrl_if.slave bus
);
  localparam int IDX_W = max_int(1, $clog2(MAX_ROUNDS));
  localparam int RND_W = $clog2(MAX_ROUNDS + 1);
  localparam int TMR_W = $clog2(max_int(SHOW_CYCLES, TIMEOUT_CYCLES) + 1);

  localparam logic [TMR_W-1:0] SHOW_LAST    = TMR_W'(SHOW_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RND_W-1:0] ROUND_LAST   = RND_W'(MAX_ROUNDS);

  state_t           state;
  moore_outs_t      outs;
  logic [IDX_W-1:0] seq_idx;
  logic [RND_W-1:0] round;
  logic [SYM_W-1:0] sym_diff;
  logic             sym_match;
  logic             at_last;
  logic             timer_clear;
  logic             timer_en;
  logic             timer_done;
  logic [TMR_W-1:0] timer_term;

  assign sym_diff  = bus.btn_sym ^ bus.seq_sym;
  assign sym_match = (sym_diff == '0);
  assign at_last   = ((RND_W'(seq_idx) + RND_W'(1)) == round);

  // The timer only runs through a symbol display or while waiting for a
  // press; every other situation (press, terminal count, abort) restarts it.
  always_comb begin
    timer_term = (state == SHOW) ? SHOW_LAST : TIMEOUT_LAST;
    timer_en   = 1'b0;
    if (bus.start && !timer_done) begin
      if (state == SHOW) begin
        timer_en = 1'b1;
      end else if ((state == INPUT) && !bus.btn_valid) begin
        timer_en = 1'b1;
      end
    end
    timer_clear = !timer_en;
  end

  cycle_timer #(.W(TMR_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (timer_clear),
    .en    (timer_en),
    .term  (timer_term),
    .done  (timer_done)
  );

  // Game sequencing with registered Moore flags; start low always wins
  // outside IDLE/SEED so a dropped request abandons the game at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      outs    <= outs_for(IDLE);
      round   <= '0;
      seq_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.lfsr_begin) begin
            state <= SEED;
            outs  <= outs_for(SEED);
          end else if (bus.start) begin
            state   <= SHOW;
            outs    <= outs_for(SHOW);
            round   <= RND_W'(1);
            seq_idx <= '0;
          end
        end
        SEED: begin
          if (!bus.lfsr_begin) begin
            state   <= IDLE;
            outs    <= outs_for(IDLE);
            round   <= '0;
            seq_idx <= '0;
          end else if (bus.start) begin
            state   <= SHOW;
            outs    <= outs_for(SHOW);
            round   <= RND_W'(1);
            seq_idx <= '0;
          end
        end
        SHOW: begin
          if (!bus.start) begin
            state   <= IDLE;
            outs    <= outs_for(IDLE);
            round   <= '0;
            seq_idx <= '0;
          end else if (timer_done) begin
            if (at_last) begin
              state   <= INPUT;
              outs    <= outs_for(INPUT);
              seq_idx <= '0;
            end else begin
              seq_idx <= seq_idx + IDX_W'(1);
            end
          end
        end
        INPUT: begin
          if (!bus.start) begin
            state   <= IDLE;
            outs    <= outs_for(IDLE);
            round   <= '0;
            seq_idx <= '0;
          end else if (bus.btn_valid) begin
            if (!sym_match) begin
              state <= LOSE;
              outs  <= outs_for(LOSE);
            end else if (at_last) begin
              if (round == ROUND_LAST) begin
                state <= WIN;
                outs  <= outs_for(WIN);
              end else begin
                state   <= SHOW;
                outs    <= outs_for(SHOW);
                round   <= round + RND_W'(1);
                seq_idx <= '0;
              end
            end else begin
              seq_idx <= seq_idx + IDX_W'(1);
            end
          end else if (timer_done) begin
            state <= LOSE;
            outs  <= outs_for(LOSE);
          end
        end
        WIN, LOSE: begin
          if (!bus.start) begin
            state   <= IDLE;
            outs    <= outs_for(IDLE);
            round   <= '0;
            seq_idx <= '0;
          end
        end
        default: begin
          state   <= IDLE;
          outs    <= outs_for(IDLE);
          round   <= '0;
          seq_idx <= '0;
        end
      endcase
    end
  end

  assign bus.lfsr_reset = outs.lfsr_reset;
  assign bus.en         = outs.en;
  assign bus.show_valid = outs.show_valid;
  assign bus.win        = outs.win;
  assign bus.lose       = outs.lose;
  assign bus.seq_idx    = seq_idx;
  assign bus.round      = round;
endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed scenarios plus randomized games, checked
// against a round/press level model of the game rules.
module tb_game_ctrl;
  localparam int MAX_ROUNDS     = 3;
  localparam int SHOW_CYCLES    = 4;
  localparam int TIMEOUT_CYCLES = 10;
  localparam int SYM_W          = 2;

  logic clk = 1'b0;
  logic reset;
  int   compared   = 0;
  int   mismatched = 0;
  logic [SYM_W-1:0] pattern [MAX_ROUNDS];

  game_ctrl_if #(.MAX_ROUNDS(MAX_ROUNDS), .SYM_W(SYM_W)) bus ();

  game_ctrl #(
    .MAX_ROUNDS     (MAX_ROUNDS),
    .SHOW_CYCLES    (SHOW_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .SYM_W          (SYM_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Combinational pattern store standing in for the LFSR sequence memory.
  assign bus.seq_sym = pattern[bus.seq_idx];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic lb, input logic bv,
                               input logic [SYM_W-1:0] bs);
    bus.start      = st;
    bus.lfsr_begin = lb;
    bus.btn_valid  = bv;
    bus.btn_sym    = bs;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".lfsr_reset"}, 32'(bus.lfsr_reset), 32'd1);
    checkOutput({tag, ".en"},         32'(bus.en),         32'd1);
    checkOutput({tag, ".round"},      32'(bus.round),      32'd0);
    checkOutput({tag, ".seq_idx"},    32'(bus.seq_idx),    32'd0);
    checkOutput({tag, ".show_valid"}, 32'(bus.show_valid), 32'd0);
    checkOutput({tag, ".win"},        32'(bus.win),        32'd0);
    checkOutput({tag, ".lose"},       32'(bus.lose),       32'd0);
  endtask

  task automatic newPattern();
    for (int k = 0; k < MAX_ROUNDS; k++) pattern[k] = SYM_W'($urandom);
  endtask

  // Plays one game already in its first SHOW cycle. kind: 0 = clean play,
  // 1 = wrong symbol at (f_round, f_idx), 2 = no press at (f_round, f_idx).
  // late makes every press land on the final allowed cycle.
  task automatic playGame(input int kind, input int f_round, input int f_idx,
                          input bit late);
    int cnt;
    int d;
    bit over;
    logic [SYM_W-1:0] sym;
    over = 1'b0;
    for (int r = 1; r <= MAX_ROUNDS; r++) begin
      if (!over) begin
        checkOutput("show_round", 32'(bus.round), 32'(r));
        checkOutput("show_en", 32'(bus.en), 32'd0);
        cnt = 0;
        while (bus.show_valid === 1'b1 && cnt < 200) begin
          bus.btn_valid = ($urandom_range(0, 5) == 0);
          bus.btn_sym   = SYM_W'($urandom);
          tick();
          cnt++;
          bus.btn_valid = 1'b0;
        end
        checkOutput("show_len", 32'(cnt), 32'(r * SHOW_CYCLES));
        for (int i = 0; i < r; i++) begin
          if (!over) begin
            if (kind == 2 && r == f_round && i == f_idx) begin
              cnt = 0;
              while (bus.lose !== 1'b1 && cnt < 50) begin
                tick();
                cnt++;
              end
              checkOutput("timeout_len", 32'(cnt), 32'(TIMEOUT_CYCLES));
              checkOutput("timeout_round", 32'(bus.round), 32'(r));
              over = 1'b1;
            end else begin
              d = late ? TIMEOUT_CYCLES - 1 : $urandom_range(0, TIMEOUT_CYCLES - 1);
              repeat (d) tick();
              sym = pattern[i];
              if (kind == 1 && r == f_round && i == f_idx)
                sym = sym ^ SYM_W'($urandom_range(1, 3));
              bus.btn_valid = 1'b1;
              bus.btn_sym   = sym;
              tick();
              bus.btn_valid = 1'b0;
              if (sym != pattern[i]) begin
                checkOutput("wrong_lose", 32'(bus.lose), 32'd1);
                checkOutput("wrong_round", 32'(bus.round), 32'(r));
                over = 1'b1;
              end else begin
                checkOutput("press_lose", 32'(bus.lose), 32'd0);
              end
            end
          end
        end
      end
    end
    if (!over) begin
      checkOutput("win", 32'(bus.win), 32'd1);
      checkOutput("win_round", 32'(bus.round), 32'(MAX_ROUNDS));
    end
    bus.start = 1'b0;
    tick();
    checkIdle("end_idle");
  endtask

  // Directed scenarios followed by randomized games.
  initial begin
    int kind;
    int fr;
    bus.start      = 1'b0;
    bus.lfsr_begin = 1'b0;
    bus.btn_valid  = 1'b0;
    bus.btn_sym    = '0;
    newPattern();
    reset = 1'b1;
    #3;
    checkIdle("reset_async");
    repeat (2) tick();
    reset = 1'b0;
    tick();
    checkIdle("reset_release");

    // Seed then start.
    repeat (5) applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput("seed_lfsr_reset", 32'(bus.lfsr_reset), 32'd0);
    checkOutput("seed_en", 32'(bus.en), 32'd1);
    checkOutput("seed_round", 32'(bus.round), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkOutput("seed_show_valid", 32'(bus.show_valid), 32'd1);
    checkOutput("seed_show_lfsr_reset", 32'(bus.lfsr_reset), 32'd0);
    checkOutput("seed_show_idx", 32'(bus.seq_idx), 32'd0);
    bus.lfsr_begin = 1'b0;
    playGame(0, 1, 0, 1'b0);

    // Wrong symbol in round 2 at index 1.
    newPattern();
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    playGame(1, 2, 1, 1'b0);

    // Timeout with no press, then presses on the last allowed cycle.
    newPattern();
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    playGame(2, 1, 0, 1'b0);
    newPattern();
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    playGame(0, 1, 0, 1'b1);

    // Abort mid-display.
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    repeat (2) tick();
    checkOutput("abort_pre_show", 32'(bus.show_valid), 32'd1);
    bus.start = 1'b0;
    tick();
    checkIdle("abort_show");

    // Asynchronous reset while waiting for a press.
    newPattern();
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    repeat (SHOW_CYCLES) tick();
    checkOutput("input_show_valid", 32'(bus.show_valid), 32'd0);
    checkOutput("input_round", 32'(bus.round), 32'd1);
    checkOutput("input_lose", 32'(bus.lose), 32'd0);
    #2 reset = 1'b1;
    #1 checkIdle("reset_mid");
    #1 reset = 1'b0;
    tick();
    checkOutput("reenter_round", 32'(bus.round), 32'd1);
    checkOutput("reenter_show", 32'(bus.show_valid), 32'd1);
    bus.start = 1'b0;
    tick();
    checkIdle("reenter_idle");

    // Randomized games.
    for (int g = 0; g < 8; g++) begin
      kind = $urandom_range(0, 2);
      fr   = $urandom_range(1, MAX_ROUNDS);
      newPattern();
      applyStimulus(1'b1, 1'b0, 1'b0, '0);
      playGame(kind, fr, $urandom_range(0, fr - 1), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter MAX_ROUNDS, default 8: number of rounds to win; legal range is 1 or more.
REQ-002 Parameter SHOW_CYCLES, default 50: clocks each sequence symbol is displayed; legal range is 1 or more.
REQ-003 Parameter TIMEOUT_CYCLES, default 1000: clocks allowed per player press; legal range is 1 or more.
REQ-004 Parameter SYM_W, default 2: symbol width, giving 2**SYM_W buttons.
REQ-005 Port clk, input, 1: single clock; all state on rising edge.
REQ-006 Port reset, input, 1: reset is asynchronous and active-high.
REQ-007 Port start, input, 1: level; high = game requested, low = abort/return to idle.
REQ-008 Port lfsr_begin, input, 1: level; high = free-run pattern LFSR for seeding.
REQ-009 Port seq_sym, input, SYM_W: pattern symbol at index seq_idx, valid same cycle (combinational source).
REQ-010 Port btn_valid, input, 1: one-cycle pulse per player press.
REQ-011 Port btn_sym, input, SYM_W: pressed symbol, qualified by btn_valid.
REQ-012 Port lfsr_reset, output, 1: hold pattern LFSR in reset.
REQ-013 Port en, output, 1: pattern LFSR advance enable.
REQ-014 Port seq_idx, output, IDX_W=max(1,$clog2(MAX_ROUNDS)): current pattern index.
REQ-015 Port show_valid, output, 1: seq_sym is being displayed.
REQ-016 Port round, output, RND_W=$clog2(MAX_ROUNDS+1): current round, 1-based; 0 in idle.
REQ-017 Port win / lose, output, 1 each: terminal result flags.

Function
REQ-018 States SHALL be IDLE, SEED, SHOW, INPUT, WIN, LOSE; Moore outputs, registered state.
REQ-019 IDLE: lfsr_reset=1, en=1; lfsr_begin -> SEED (priority); else start -> SHOW with round=1, seq_idx=0, timer=0; else stay.
REQ-020 SEED: lfsr_reset=0, en=1; lfsr_begin low -> IDLE (priority); else start -> SHOW as in REQ-019; else stay.
REQ-021 SHOW, INPUT, WIN, LOSE: lfsr_reset=0, en=0 (pattern frozen).
REQ-022 SHOW: show_valid=1; timer counts 0..SHOW_CYCLES-1; at terminal count, if seq_idx==round-1 -> INPUT with seq_idx=0, timer=0; else seq_idx+1, timer=0.
REQ-023 INPUT: timer increments each cycle without btn_valid; reaching TIMEOUT_CYCLES-1 without a press -> LOSE.
REQ-024 INPUT, btn_valid and btn_sym!=seq_sym -> LOSE.
REQ-025 INPUT, btn_valid, match, seq_idx<round-1 -> seq_idx+1, timer=0.
REQ-026 INPUT, btn_valid, match, seq_idx==round-1: if round==MAX_ROUNDS -> WIN; else round+1, seq_idx=0, timer=0 -> SHOW.
REQ-027 btn_valid coincident with timeout cycle SHALL be evaluated as a press (press wins).
REQ-028 btn_valid outside INPUT SHALL be ignored.
REQ-029 WIN: win=1; LOSE: lose=1; both hold round value; start low -> IDLE.
REQ-030 start low in SHOW or INPUT SHALL abort to IDLE next cycle, overriding all other transitions.
REQ-031 Entering IDLE SHALL clear round, seq_idx, timer, win, lose.
REQ-032 Timer width SHALL be $clog2(max(SHOW_CYCLES,TIMEOUT_CYCLES)+1); no counter may wrap.

Reset
REQ-033 reset SHALL force IDLE, lfsr_reset=1, en=1, round=0, seq_idx=0, show_valid=0, win=0, lose=0, timer=0, immediately and regardless of clk.
REQ-034 Reset asserted mid-SHOW/INPUT SHALL abandon the game; after release the block re-enters via REQ-019 only.

Structure
REQ-035 State enum and default parameter constants SHALL live in shared package game_pkg.
REQ-036 One sub-module, cycle_timer (load/clear, enable, terminal-count compare), SHALL be used for the timer.

Verification (MAX_ROUNDS=3, SHOW_CYCLES=4, TIMEOUT_CYCLES=10)
REQ-037 lfsr_begin=1 for 5 cycles, then start=1 -> SEED with lfsr_reset=0, en=1, then SHOW with round=1, en=0.
REQ-038 Correct presses every round -> show_valid for 4, 8, 12 cycles in rounds 1-3; win=1 after 6th correct press.
REQ-039 Round 2, press wrong symbol at seq_idx=1 -> lose=1 next cycle, round=2 held.
REQ-040 INPUT with no press for 10 cycles -> lose=1; press on cycle 9 with correct symbol -> no lose.
REQ-041 start dropped mid-SHOW -> IDLE next cycle, round=0, lfsr_reset=1.
REQ-042 reset asserted between clock edges in INPUT -> outputs at reset values before next edge.
